// File: rtl/ocp_pkg.sv
// ---------------------------------------------------------------------------
// ocp_pkg
// Shared OCP 2.2 definitions for the request-phase master controller:
//   - mcmd_e  : MCmd encodings (IDLE..BCST); the master FSM only ever issues
//               IDLE, WR and RD, and uses this type directly as its state.
//   - sresp_e : SResp encodings (NULL/DVA/FAIL/ERR).
//   - width defaults for address / data buses and the burst-length field.
// ---------------------------------------------------------------------------
package ocp_pkg;

  localparam int MADDR_WIDTH_DEF = 64;
  localparam int MDATA_WIDTH_DEF = 8;
  localparam int SDATA_WIDTH_DEF = 8;
  localparam int BURST_LEN_W     = 10;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'b000,
    MCMD_WR   = 3'b001,
    MCMD_RD   = 3'b010,
    MCMD_RDEX = 3'b011,
    MCMD_RDL  = 3'b100,
    MCMD_WRNP = 3'b101,
    MCMD_WRC  = 3'b110,
    MCMD_BCST = 3'b111
  } mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'b00,
    SRESP_DVA  = 2'b01,
    SRESP_FAIL = 2'b10,
    SRESP_ERR  = 2'b11
  } sresp_e;

  localparam logic [2:0] BURST_SEQ_INCR = 3'b000;

endpackage

// File: rtl/ocp_master_fsm.sv
// ---------------------------------------------------------------------------
// ocp_master_fsm
// OCP 2.2 master request-phase controller. Converts one-cycle bridge
// read/write pulses into OCP WR/RD commands with precise incrementing bursts,
// holding each request beat until SCmdAccept and flagging the final beat on
// MReqLast.
//
// Ports:
//   sys_clk, reset          system clock, asynchronous active-low reset
//   enable                  1 = new bridge requests may be accepted
//   address, write_data     bridge address / data, sampled live each beat
//   burst_length            beats in burst (0 treated as 1)
//   burst_seq               burst sequence; only INCR is implemented
//   burst_single_req        1 = whole burst issued as a single request beat
//   read_request,
//   write_request           one-cycle start pulses (write wins if both)
//   SCmdAccept              slave accepts the current request beat
//   SData, SResp            slave response (monitored only)
//   Clk, EnableClk          OCP clock (= sys_clk) and constant clock enable
//   MCmd                    registered command = FSM state
//   MAddr, MData,
//   MBurstLength            request fields, zero while idle
//   MReqLast                current beat is the last request beat
// ---------------------------------------------------------------------------
module ocp_master_fsm
  import ocp_pkg::*;
#(
  parameter int MADDR_WIDTH = MADDR_WIDTH_DEF,
  parameter int MDATA_WIDTH = MDATA_WIDTH_DEF,
  parameter int SDATA_WIDTH = SDATA_WIDTH_DEF
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [MADDR_WIDTH-1:0] address,
  input  logic [BURST_LEN_W-1:0] burst_length,
  input  logic [2:0]             burst_seq,
  input  logic                   burst_single_req,
  input  logic                   read_request,
  input  logic                   write_request,
  input  logic [MDATA_WIDTH-1:0] write_data,
  input  logic                   SCmdAccept,
  input  logic [SDATA_WIDTH-1:0] SData,
  input  logic [1:0]             SResp,
  output logic                   Clk,
  output logic                   EnableClk,
  output logic [MADDR_WIDTH-1:0] MAddr,
  output logic [BURST_LEN_W-1:0] MBurstLength,
  output logic [2:0]             MCmd,
  output logic [MDATA_WIDTH-1:0] MData,
  output logic                   MReqLast
);

  mcmd_e                  state;
  logic [BURST_LEN_W-1:0] cnt;
  logic [BURST_LEN_W-1:0] load_cnt;
  logic                   busy;

  // Responses are consumed downstream and the burst sequence is always
  // treated as INCR, so these inputs intentionally do not steer the FSM.
  logic unused_inputs;
  assign unused_inputs = ^{burst_seq, SData, SResp};

  // A single-request burst, or a zero length, is one request beat.
  assign load_cnt = (burst_single_req || (burst_length == '0))
                    ? BURST_LEN_W'(1) : burst_length;

  assign busy = (state != MCMD_IDLE);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state <= MCMD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MCMD_IDLE: begin
          if (enable && write_request) begin
            state <= MCMD_WR;
            cnt   <= load_cnt;
          end else if (enable && read_request) begin
            state <= MCMD_RD;
            cnt   <= load_cnt;
          end
        end
        MCMD_WR, MCMD_RD: begin
          // A command once presented cannot be withdrawn, so enable and
          // further requests are ignored until the last beat is accepted.
          if (SCmdAccept) begin
            if (cnt == BURST_LEN_W'(1)) begin
              state <= MCMD_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - BURST_LEN_W'(1);
            end
          end
        end
        default: begin
          state <= MCMD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Request fields follow the live bridge inputs and collapse to zero when
  // idle; because they derive from state, async reset clears them at once.
  always_comb begin
    MAddr        = '0;
    MBurstLength = '0;
    MData        = '0;
    if (busy) begin
      MAddr        = address;
      MBurstLength = burst_length;
      if (state == MCMD_WR) MData = write_data;
    end
  end

  assign MCmd      = state;
  assign MReqLast  = busy && (cnt == BURST_LEN_W'(1));
  assign Clk       = sys_clk;
  assign EnableClk = 1'b1;

endmodule

// File: tb/tb_ocp_master_fsm.sv
module tb_ocp_master_fsm;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] address;
  logic [9:0]  burst_length;
  logic [2:0]  burst_seq;
  logic        burst_single_req;
  logic        read_request;
  logic        write_request;
  logic [7:0]  write_data;
  logic        SCmdAccept;
  logic [7:0]  SData;
  logic [1:0]  SResp;
  logic        Clk;
  logic        EnableClk;
  logic [63:0] MAddr;
  logic [9:0]  MBurstLength;
  logic [2:0]  MCmd;
  logic [7:0]  MData;
  logic        MReqLast;

  int checks   = 0;
  int failures = 0;

  ocp_master_fsm #(
    .MADDR_WIDTH(64),
    .MDATA_WIDTH(8),
    .SDATA_WIDTH(8)
  ) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .enable          (enable),
    .address         (address),
    .burst_length    (burst_length),
    .burst_seq       (burst_seq),
    .burst_single_req(burst_single_req),
    .read_request    (read_request),
    .write_request   (write_request),
    .write_data      (write_data),
    .SCmdAccept      (SCmdAccept),
    .SData           (SData),
    .SResp           (SResp),
    .Clk             (Clk),
    .EnableClk       (EnableClk),
    .MAddr           (MAddr),
    .MBurstLength    (MBurstLength),
    .MCmd            (MCmd),
    .MData           (MData),
    .MReqLast        (MReqLast)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; address = 64'h1234; burst_length = 10'd3;
    burst_seq = 3'b000; burst_single_req = 1'b0; read_request = 1'b0;
    write_request = 1'b0; write_data = 8'hAA; SCmdAccept = 1'b0;
    SData = 8'h00; SResp = 2'b00;
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL reset_mcmd got=%b exp=000", MCmd); end
    checks++; if (MAddr !== 64'h0) begin failures++; $display("FAIL reset_maddr got=%h exp=0", MAddr); end
    checks++; if (MData !== 8'h00) begin failures++; $display("FAIL reset_mdata got=%h exp=00", MData); end
    checks++; if (MBurstLength !== 10'd0) begin failures++; $display("FAIL reset_mburstlen got=%0d exp=0", MBurstLength); end
    checks++; if (MReqLast !== 1'b0) begin failures++; $display("FAIL reset_mreqlast got=%b exp=0", MReqLast); end
    checks++; if (EnableClk !== 1'b1) begin failures++; $display("FAIL enableclk got=%b exp=1", EnableClk); end
    checks++; if (Clk !== 1'b1) begin failures++; $display("FAIL clk_high got=%b exp=1", Clk); end
    #5;
    checks++; if (Clk !== 1'b0) begin failures++; $display("FAIL clk_low got=%b exp=0", Clk); end
    tick();
  endtask

  task automatic test_single_write();
    enable = 1'b1; address = 64'hFFFF_FFFF_FFFF_FFFF; burst_length = 10'd1;
    write_data = 8'hFF; write_request = 1'b1;
    tick();
    write_request = 1'b0; #1;
    checks++; if (MCmd !== 3'b001) begin failures++; $display("FAIL sw_mcmd got=%b exp=001", MCmd); end
    checks++; if (MReqLast !== 1'b1) begin failures++; $display("FAIL sw_mreqlast got=%b exp=1", MReqLast); end
    checks++; if (MData !== 8'hFF) begin failures++; $display("FAIL sw_mdata got=%h exp=ff", MData); end
    checks++; if (MAddr !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sw_maddr got=%h exp=ffffffffffffffff", MAddr); end
    checks++; if (MBurstLength !== 10'd1) begin failures++; $display("FAIL sw_mburstlen got=%0d exp=1", MBurstLength); end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL sw_idle got=%b exp=000", MCmd); end
    checks++; if (MAddr !== 64'h0) begin failures++; $display("FAIL sw_idle_maddr got=%h exp=0", MAddr); end
  endtask

  task automatic test_single_read();
    read_request = 1'b1;
    tick();
    read_request = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (MCmd !== 3'b010) begin failures++; $display("FAIL sr_hold%0d got=%b exp=010", i, MCmd); end
      checks++; if (MData !== 8'h00) begin failures++; $display("FAIL sr_mdata%0d got=%h exp=00", i, MData); end
      tick();
    end
    checks++; if (MReqLast !== 1'b1) begin failures++; $display("FAIL sr_mreqlast got=%b exp=1", MReqLast); end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0; SResp = 2'b01; SData = 8'hFF; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL sr_idle got=%b exp=000", MCmd); end
    tick();
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL sr_resp_noeffect got=%b exp=000", MCmd); end
    SResp = 2'b00; SData = 8'h00;
  endtask

  task automatic test_incr_write_burst();
    burst_length = 10'd4; write_request = 1'b1;
    tick();
    write_request = 1'b0; SCmdAccept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = 64'(4 * i); write_data = 8'(i); #1;
      checks++; if (MCmd !== 3'b001) begin failures++; $display("FAIL wb_mcmd%0d got=%b exp=001", i, MCmd); end
      checks++; if (MAddr !== 64'(4 * i)) begin failures++; $display("FAIL wb_maddr%0d got=%h exp=%h", i, MAddr, 64'(4 * i)); end
      checks++; if (MData !== 8'(i)) begin failures++; $display("FAIL wb_mdata%0d got=%h exp=%h", i, MData, 8'(i)); end
      checks++; if (MReqLast !== (i == 3)) begin failures++; $display("FAIL wb_mreqlast%0d got=%b exp=%b", i, MReqLast, (i == 3)); end
      tick();
    end
    SCmdAccept = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL wb_idle got=%b exp=000", MCmd); end
  endtask

  task automatic test_burst_read();
    burst_length = 10'd4; read_request = 1'b1;
    tick();
    read_request = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (MCmd !== 3'b010 || MReqLast !== 1'b0) begin failures++; $display("FAIL rb_hold%0d got=%b/%b exp=010/0", i, MCmd, MReqLast); end
      tick();
    end
    SCmdAccept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (MCmd !== 3'b010 || MReqLast !== (i == 3)) begin failures++; $display("FAIL rb_beat%0d got=%b/%b exp=010/%b", i, MCmd, MReqLast, (i == 3)); end
      tick();
    end
    SCmdAccept = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL rb_idle got=%b exp=000", MCmd); end
    // Single-request burst: one beat carrying the full length.
    burst_single_req = 1'b1; read_request = 1'b1;
    tick();
    read_request = 1'b0; #1;
    checks++; if (MCmd !== 3'b010 || MReqLast !== 1'b1) begin failures++; $display("FAIL rb_single got=%b/%b exp=010/1", MCmd, MReqLast); end
    checks++; if (MBurstLength !== 10'd4) begin failures++; $display("FAIL rb_single_len got=%0d exp=4", MBurstLength); end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0; burst_single_req = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL rb_single_idle got=%b exp=000", MCmd); end
    // Zero length behaves as a single beat.
    burst_length = 10'd0; read_request = 1'b1;
    tick();
    read_request = 1'b0; #1;
    checks++; if (MReqLast !== 1'b1) begin failures++; $display("FAIL rb_len0 got=%b exp=1", MReqLast); end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL rb_len0_idle got=%b exp=000", MCmd); end
  endtask

  task automatic test_simultaneous();
    burst_length = 10'd1; read_request = 1'b1; write_request = 1'b1;
    tick();
    read_request = 1'b0; write_request = 1'b0; #1;
    checks++; if (MCmd !== 3'b001) begin failures++; $display("FAIL simul_wr got=%b exp=001", MCmd); end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL simul_idle got=%b exp=000", MCmd); end
  endtask

  task automatic test_enable_low();
    enable = 1'b0; write_request = 1'b1;
    tick();
    write_request = 1'b0; read_request = 1'b1; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL en0_wr got=%b exp=000", MCmd); end
    tick();
    read_request = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL en0_rd got=%b exp=000", MCmd); end
    // Enable dropped mid-burst: burst completes, new requests dropped.
    enable = 1'b1; burst_length = 10'd2; write_request = 1'b1;
    tick();
    write_request = 1'b0; enable = 1'b0; read_request = 1'b1; SCmdAccept = 1'b1; #1;
    checks++; if (MCmd !== 3'b001 || MReqLast !== 1'b0) begin failures++; $display("FAIL en_mid_b0 got=%b/%b exp=001/0", MCmd, MReqLast); end
    tick();
    enable = 1'b1; #1;
    checks++; if (MCmd !== 3'b001 || MReqLast !== 1'b1) begin failures++; $display("FAIL en_mid_b1 got=%b/%b exp=001/1", MCmd, MReqLast); end
    tick();
    read_request = 1'b0; SCmdAccept = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL en_mid_drop got=%b exp=000", MCmd); end
    tick();
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL en_mid_idle got=%b exp=000", MCmd); end
  endtask

  task automatic test_reset_mid_burst();
    enable = 1'b1; burst_length = 10'd4; address = 64'h40; write_data = 8'h5A; write_request = 1'b1;
    tick();
    write_request = 1'b0; SCmdAccept = 1'b1;
    tick();
    checks++; if (MCmd !== 3'b001) begin failures++; $display("FAIL rmb_pre got=%b exp=001", MCmd); end
    reset = 1'b0; #1;
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL rmb_mcmd got=%b exp=000", MCmd); end
    checks++; if (MAddr !== 64'h0 || MData !== 8'h00 || MReqLast !== 1'b0) begin failures++; $display("FAIL rmb_outs got=%h/%h/%b exp=0/0/0", MAddr, MData, MReqLast); end
    SCmdAccept = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (MCmd !== 3'b000) begin failures++; $display("FAIL rmb_after got=%b exp=000", MCmd); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_incr_write_burst();
    test_burst_read();
    test_simultaneous();
    test_enable_low();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
